pcm_frame_pairer: RTL and testbench
===================================

PCM_FRAME_PAIRER -- requirements
Module: pcm_frame_pairer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, frame FIFO depth; power of 2, range 2..16.
REQ-002 Parameter: SAMPLE_W, default 24, PCM sample width.
REQ-003 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: l_data_en  in  1  left-sample strobe from the I2S deserialiser; may stay high for several clk cycles.
REQ-006 Port: r_data_en  in  1  right-sample strobe; same behaviour as l_data_en.
REQ-007 Port: l_data  in  SAMPLE_W  left sample, two's complement.
REQ-008 Port: r_data  in  SAMPLE_W  right sample, two's complement.
REQ-009 Port: frame_ready  in  1  downstream accepts a frame.
REQ-010 Port: clear_overflow  in  1  single-cycle clear of overflow.
REQ-011 Port: frame_valid  out  1  FIFO head frame valid.
REQ-012 Port: frame_l  out  SAMPLE_W  left sample of head frame.
REQ-013 Port: frame_r  out  SAMPLE_W  right sample of head frame.
REQ-014 Port: fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored.
REQ-015 Port: overflow  out  1  sticky; a completed frame was dropped.
REQ-016 Port: sync_err  out  1  one-cycle pulse on an L/R ordering violation.

Function
REQ-017 Strobe handling: a strobe event is only the 0->1 transition of l_data_en or r_data_en, detected against a registered copy; held-high levels generate no further events.
REQ-018 Data capture: l_data or r_data is sampled in the same cycle as its strobe event.
REQ-019 FSM states: WAIT_L (reset state) and WAIT_R.
REQ-020 WAIT_L, left event: capture left into hold register; go to WAIT_R.
REQ-021 WAIT_L, right event only: discard sample; pulse sync_err; stay in WAIT_L.
REQ-022 WAIT_R, right event: push {held left, r_data} to FIFO; go to WAIT_L.
REQ-023 WAIT_R, left event only: overwrite held left; pulse sync_err; stay in WAIT_R.
REQ-024 Simultaneous left and right events in either state: discard both; pulse sync_err; go to WAIT_L.
REQ-025 FIFO read is first-word-fall-through: frame_valid equals not-empty; frame_l and frame_r show the head frame combinationally from storage.
REQ-026 Pop occurs when frame_valid and frame_ready are both high in a cycle.
REQ-027 Latency: a pushed frame is visible on frame_valid in the next cycle.
REQ-028 Push while full without a pop: frame dropped; FIFO unchanged; overflow set in the next cycle.
REQ-029 Push while full with a simultaneous pop: push accepted; no overflow.
REQ-030 Push and pop in the same cycle while non-empty: fifo_level unchanged.
REQ-031 Pointers wrap modulo FIFO_DEPTH; fifo_level saturates at FIFO_DEPTH and never underflows; frame_ready while empty is ignored.
REQ-032 overflow is cleared by clear_overflow; if a set and a clear occur in the same cycle, the set wins.
REQ-033 Data passes bit-exact; no arithmetic is performed on samples.

Reset
REQ-034 While reset is high: FSM enters WAIT_L; FIFO is emptied; frame_valid=0, fifo_level=0, overflow=0, sync_err=0, frame_l=frame_r=0, hold register=0, strobe history=0.
REQ-035 Reset mid-frame discards the held left and all buffered frames; a strobe already high when reset releases produces no event.

Configuration
REQ-036 Macro PCM_FRAME_PAIRER_ERR_CNT_EN defined: add output port sync_err_cnt (8 bits); it increments on each sync_err pulse, saturates at 255, and resets to 0.
REQ-037 Macro not defined: the sync_err_cnt port and its counter are absent; all other behaviour is identical.

Structure
REQ-038 Shared package pcm_audio_pkg: SAMPLE_W constant, stereo-frame struct typedef {left, right}, and the FSM state enum.
REQ-039 The FIFO is a sub-module, pcm_frame_fifo, parameterised by depth and frame type, providing push, pop, full, empty and level.

Verification
REQ-040 L strobe with l_data=0x123456 held 5 cycles, then R strobe with r_data=0xABCDEF -> exactly one frame {0x123456, 0xABCDEF}; frame_valid high one cycle after the R event.
REQ-041 frame_ready=0; 5 complete frames with FIFO_DEPTH=4 -> fifo_level=4; overflow=1 after the 5th frame; the first 4 frames are read out intact in order.
REQ-042 Full FIFO; final R event in the same cycle as a pop -> fifo_level stays 4; overflow stays 0.
REQ-043 R event, L, L, R with samples 1, 2, 3, 4 -> two sync_err pulses; single frame {3, 4}; with the macro defined, sync_err_cnt=2.
REQ-044 L and R rising in the same cycle -> sync_err pulse; no frame; FSM in WAIT_L.
REQ-045 Reset asserted in WAIT_R with 2 frames buffered -> frame_valid=0 and fifo_level=0 next cycle; a following R-first sequence causes sync_err.

Source files
------------

// File: rtl/pcm_audio_pkg.sv
// -----------------------------------------------------------------------------
// pcm_audio_pkg
// Shared definitions for the PCM stereo-frame pairing logic:
//   SAMPLE_W        default PCM sample width
//   stereo_frame_t  packed {left, right} stereo frame
//   pair_state_e    L/R pairing FSM states
//   ERR_CNT_MAX     saturation value of the optional sync-error counter
// -----------------------------------------------------------------------------
package pcm_audio_pkg;

  localparam int SAMPLE_W = 24;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_frame_t;

  typedef enum logic [0:0] {
    WAIT_L = 1'b0,
    WAIT_R = 1'b1
  } pair_state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/pcm_frame_fifo.sv
// -----------------------------------------------------------------------------
// pcm_frame_fifo
// First-word-fall-through frame FIFO. The head entry is presented
// combinationally from storage; a push while full is accepted only when a pop
// frees a slot in the same cycle, otherwise it is ignored.
// Parameters:
//   DEPTH    number of entries, power of 2 (2..16)
//   frame_t  stored entry type
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push, push_data  write request and entry
//   pop              read request (ignored while empty)
//   head             entry at the read pointer
//   full, empty      occupancy flags
//   level            entries stored, 0..DEPTH
// -----------------------------------------------------------------------------
module pcm_frame_fifo
  import pcm_audio_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type frame_t = stereo_frame_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  frame_t                   push_data,
  input  logic                     pop,
  output frame_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  frame_t             mem_q [DEPTH];
  frame_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [PTR_W:0]     lvl_q, lvl_d;
  logic               push_ok;
  logic               pop_ok;

  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == FULL_LVL);
  assign pop_ok  = pop & ~empty;
  // A full FIFO can still take a push when the same cycle pops the head.
  assign push_ok = push & (~full | pop_ok);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;   // power-of-2 depth: wraps naturally
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  // NOTE: storage is reset along with the pointers so the head output reads
  // zero while empty after reset; at these depths the cost is negligible.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign level = lvl_q;

endmodule

// File: rtl/pcm_frame_pairer.sv
// -----------------------------------------------------------------------------
// pcm_frame_pairer
// Pairs left/right PCM samples from an I2S deserialiser into stereo frames and
// buffers them in a first-word-fall-through FIFO.
// Strobes are edge-detected: only a 0->1 transition of l_data_en/r_data_en is
// an event, and the sample is captured in that cycle. A left event followed by
// a right event forms one frame; out-of-order or simultaneous events raise a
// one-cycle sync_err (registered, one cycle after the offending event).
// Parameters:
//   FIFO_DEPTH  frame FIFO depth, power of 2 (2..16)
//   SAMPLE_W    PCM sample width
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   l_data_en, l_data          left strobe and sample
//   r_data_en, r_data          right strobe and sample
//   frame_ready                downstream accepts the head frame
//   clear_overflow             clears the sticky overflow flag
//   frame_valid                head frame valid (FIFO not empty)
//   frame_l, frame_r           head frame samples
//   fifo_level                 frames stored
//   overflow                   sticky: a completed frame was dropped
//   sync_err                   one-cycle L/R ordering violation pulse
//   sync_err_cnt               saturating count of sync_err pulses, present
//                              only when PCM_FRAME_PAIRER_ERR_CNT_EN is defined
// -----------------------------------------------------------------------------
module pcm_frame_pairer
  import pcm_audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_W   = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          l_data_en,
  input  logic                          r_data_en,
  input  logic [SAMPLE_W-1:0]           l_data,
  input  logic [SAMPLE_W-1:0]           r_data,
  input  logic                          frame_ready,
  input  logic                          clear_overflow,
  output logic                          frame_valid,
  output logic [SAMPLE_W-1:0]           frame_l,
  output logic [SAMPLE_W-1:0]           frame_r,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          sync_err
`ifdef PCM_FRAME_PAIRER_ERR_CNT_EN
  ,
  output logic [7:0]                    sync_err_cnt
`endif
);

  // Same layout as stereo_frame_t, but sized by this instance's SAMPLE_W.
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

  pair_state_e          state_q, state_d;
  logic [SAMPLE_W-1:0]  hold_q, hold_d;
  logic                 l_en_q, l_en_d;
  logic                 r_en_q, r_en_d;
  logic                 rst_mask_q, rst_mask_d;
  logic                 sync_err_q, sync_err_d;
  logic                 overflow_q, overflow_d;

  logic                 l_evt, r_evt;
  logic                 push, pop;
  frame_t               push_frame;
  frame_t               head_frame;
  logic                 fifo_full, fifo_empty;

  // The strobe history is cleared by reset, so a strobe already high at
  // release would look like a rising edge. rst_mask_q suppresses events for
  // the first cycle after reset while the history catches up.
  assign l_evt = l_data_en & ~l_en_q & ~rst_mask_q;
  assign r_evt = r_data_en & ~r_en_q & ~rst_mask_q;

  assign l_en_d     = l_data_en;
  assign r_en_d     = r_data_en;
  assign rst_mask_d = 1'b0;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    sync_err_d = 1'b0;
    push       = 1'b0;
    push_frame = '{left: hold_q, right: r_data};
    if (l_evt && r_evt) begin
      // Cannot tell which sample belongs to which frame: drop both.
      sync_err_d = 1'b1;
      state_d    = WAIT_L;
    end else begin
      case (state_q)
        WAIT_L: begin
          if (l_evt) begin
            hold_d  = l_data;
            state_d = WAIT_R;
          end else if (r_evt) begin
            sync_err_d = 1'b1;
          end
        end
        WAIT_R: begin
          if (r_evt) begin
            push    = 1'b1;
            state_d = WAIT_L;
          end else if (l_evt) begin
            // Newest left wins; the stale one has no partner.
            hold_d     = l_data;
            sync_err_d = 1'b1;
          end
        end
        default: state_d = WAIT_L;
      endcase
    end
  end

  assign pop = ~fifo_empty & frame_ready;

  // Set has priority over clear so a drop is never lost.
  assign overflow_d = (overflow_q & ~clear_overflow) | (push & fifo_full & ~pop);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_L;
      hold_q     <= '0;
      l_en_q     <= 1'b0;
      r_en_q     <= 1'b0;
      rst_mask_q <= 1'b1;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      l_en_q     <= l_en_d;
      r_en_q     <= r_en_d;
      rst_mask_q <= rst_mask_d;
      sync_err_q <= sync_err_d;
      overflow_q <= overflow_d;
    end
  end

  pcm_frame_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .frame_t (frame_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_frame),
    .pop       (pop),
    .head      (head_frame),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign frame_valid = ~fifo_empty;
  assign frame_l     = head_frame.left;
  assign frame_r     = head_frame.right;
  assign overflow    = overflow_q;
  assign sync_err    = sync_err_q;

`ifdef PCM_FRAME_PAIRER_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts alongside the registered pulse so both update on the same edge.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sync_err_d && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign sync_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pcm_frame_pairer.sv
// -----------------------------------------------------------------------------
// tb_pcm_frame_pairer
// Directed-vector bench for pcm_frame_pairer (FIFO_DEPTH=4, SAMPLE_W=24).
// Inputs change 1 time unit after a rising edge; outputs are checked there,
// after the edge has settled. Define PCM_FRAME_PAIRER_ERR_CNT_EN to also
// exercise the sync-error counter.
// -----------------------------------------------------------------------------
module tb_pcm_frame_pairer;

  logic        clk = 1'b0;
  logic        reset;
  logic        l_data_en, r_data_en;
  logic [23:0] l_data, r_data;
  logic        frame_ready, clear_overflow;
  logic        frame_valid;
  logic [23:0] frame_l, frame_r;
  logic [2:0]  fifo_level;
  logic        overflow, sync_err;
`ifdef PCM_FRAME_PAIRER_ERR_CNT_EN
  logic [7:0]  sync_err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pcm_frame_pairer #(
    .FIFO_DEPTH (4),
    .SAMPLE_W   (24)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .l_data_en      (l_data_en),
    .r_data_en      (r_data_en),
    .l_data         (l_data),
    .r_data         (r_data),
    .frame_ready    (frame_ready),
    .clear_overflow (clear_overflow),
    .frame_valid    (frame_valid),
    .frame_l        (frame_l),
    .frame_r        (frame_r),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .sync_err       (sync_err)
`ifdef PCM_FRAME_PAIRER_ERR_CNT_EN
    ,
    .sync_err_cnt   (sync_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One complete L-then-R frame, 4 cycles; the push lands on the third edge.
  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    l_data = l; l_data_en = 1'b1; tick();
    l_data_en = 1'b0; tick();
    r_data = r; r_data_en = 1'b1; tick();
    r_data_en = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; l_data_en = 1'b1; l_data = 24'h555555;
    tick(); tick();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", frame_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rst_sync_err got %b exp 0", sync_err); end
    checks++; if ({frame_l, frame_r} !== 48'h0) begin errors++; $display("FAIL rst_frame got %h exp 0", {frame_l, frame_r}); end
    // Left strobe stays high across release: must not count as an event.
    reset = 1'b0; tick(); tick();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rst_release_sync got %b exp 0", sync_err); end
    r_data = 24'h000007; r_data_en = 1'b1; tick();
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL rst_held_l_no_event got %b exp 1", sync_err); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_held_l_level got %0d exp 0", fifo_level); end
    l_data_en = 1'b0; r_data_en = 1'b0; tick();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_err_one_cycle got %b exp 0", sync_err); end
  endtask

  task automatic test_basic_frame();
    l_data = 24'h123456; l_data_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (sync_err !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("FAIL basic_hold%0d sync_err %b valid %b exp 0 0", i, sync_err, frame_valid); end
    end
    l_data_en = 1'b0; l_data = 24'h000000; tick();
    r_data = 24'hABCDEF; r_data_en = 1'b1; tick();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", frame_valid); end
    checks++; if (frame_l !== 24'h123456) begin errors++; $display("FAIL basic_l got %h exp 123456", frame_l); end
    checks++; if (frame_r !== 24'hABCDEF) begin errors++; $display("FAIL basic_r got %h exp abcdef", frame_r); end
    r_data_en = 1'b0; tick(); tick();
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL basic_level got %0d exp 1", fifo_level); end
    frame_ready = 1'b1; tick();
    checks++; if (frame_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL basic_pop valid %b level %0d exp 0 0", frame_valid, fifo_level); end
    tick();  // ready while empty: no underflow
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL empty_pop_level got %0d exp 0", fifo_level); end
    frame_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [23:0] el, er;
    for (int i = 0; i < 5; i++) begin
      send_frame(24'h000100 + 24'(i), 24'h000200 + 24'(i));
      if (i == 3) begin
        checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_fill level %0d ovf %b exp 4 0", fifo_level, overflow); end
      end
    end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      el = 24'h000100 + 24'(i);
      er = 24'h000200 + 24'(i);
      checks++; if (frame_l !== el || frame_r !== er) begin errors++; $display("FAIL ovf_read%0d got %h/%h exp %h/%h", i, frame_l, frame_r, el, er); end
      tick();
    end
    frame_ready = 1'b0;
    checks++; if (frame_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drained valid %b ovf %b exp 0 1", frame_valid, overflow); end
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [23:0] el, er;
    for (int i = 0; i < 4; i++) send_frame(24'h000300 + 24'(i), 24'h000400 + 24'(i));
    l_data = 24'h000304; l_data_en = 1'b1; tick();
    l_data_en = 1'b0; tick();
    r_data = 24'h000404; r_data_en = 1'b1; frame_ready = 1'b1; tick();
    frame_ready = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpp_level got %0d exp 4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got %b exp 0", overflow); end
    r_data_en = 1'b0; tick();
    frame_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      el = 24'h000300 + 24'(i);
      er = 24'h000400 + 24'(i);
      checks++; if (frame_l !== el || frame_r !== er) begin errors++; $display("FAIL fullpp_read%0d got %h/%h exp %h/%h", i, frame_l, frame_r, el, er); end
      tick();
    end
    frame_ready = 1'b0;
    checks++; if (frame_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL fullpp_end valid %b ovf %b exp 0 0", frame_valid, overflow); end
  endtask

  task automatic test_sync_order();
    do_reset();
    r_data = 24'd1; r_data_en = 1'b1; tick();
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_r_first got %b exp 1", sync_err); end
    r_data_en = 1'b0; tick();
    l_data = 24'd2; l_data_en = 1'b1; tick();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_l1 got %b exp 0", sync_err); end
    l_data_en = 1'b0; tick();
    l_data = 24'd3; l_data_en = 1'b1; tick();
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_l2 got %b exp 1", sync_err); end
    l_data_en = 1'b0; tick();
    r_data = 24'd4; r_data_en = 1'b1; tick();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_r got %b exp 0", sync_err); end
    r_data_en = 1'b0; tick();
    checks++; if (fifo_level !== 3'd1 || frame_l !== 24'd3 || frame_r !== 24'd4) begin errors++; $display("FAIL sync_frame level %0d frame %h/%h exp 1 3/4", fifo_level, frame_l, frame_r); end
`ifdef PCM_FRAME_PAIRER_ERR_CNT_EN
    checks++; if (sync_err_cnt !== 8'd2) begin errors++; $display("FAIL sync_cnt got %0d exp 2", sync_err_cnt); end
`endif
    frame_ready = 1'b1; tick(); frame_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    l_data = 24'h0000AA; l_data_en = 1'b1; tick();
    l_data_en = 1'b0; tick();
    l_data = 24'h0000BB; r_data = 24'h0000CC;
    l_data_en = 1'b1; r_data_en = 1'b1; tick();
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL simul_sync got %b exp 1", sync_err); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL simul_level got %0d exp 0", fifo_level); end
    l_data_en = 1'b0; r_data_en = 1'b0; tick();
    // Back in WAIT_L: a lone right event is an error, not a push.
    r_data = 24'h0000DD; r_data_en = 1'b1; tick();
    checks++; if (sync_err !== 1'b1 || fifo_level !== 3'd0) begin errors++; $display("FAIL simul_wait_l sync %b level %0d exp 1 0", sync_err, fifo_level); end
    r_data_en = 1'b0; tick();
`ifdef PCM_FRAME_PAIRER_ERR_CNT_EN
    checks++; if (sync_err_cnt !== 8'd4) begin errors++; $display("FAIL simul_cnt got %0d exp 4", sync_err_cnt); end
`endif
  endtask

  task automatic test_set_wins();
    for (int i = 0; i < 4; i++) send_frame(24'h000500 + 24'(i), 24'h000600 + 24'(i));
    l_data = 24'h000504; l_data_en = 1'b1; tick();
    l_data_en = 1'b0; tick();
    r_data = 24'h000604; r_data_en = 1'b1; clear_overflow = 1'b1; tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", overflow); end
    checks++; if (fifo_level !== 3'd4 || frame_l !== 24'h000500) begin errors++; $display("FAIL set_wins_fifo level %0d head %h exp 4 000500", fifo_level, frame_l); end
    r_data_en = 1'b0; clear_overflow = 1'b0; tick();
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_after got %b exp 0", overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(24'h000701, 24'h000801);
    send_frame(24'h000702, 24'h000802);
    l_data = 24'h000703; l_data_en = 1'b1; tick();
    l_data_en = 1'b0; tick();
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL mid_level_pre got %0d exp 2", fifo_level); end
    reset = 1'b1; tick();
    checks++; if (frame_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL mid_reset valid %b level %0d exp 0 0", frame_valid, fifo_level); end
    checks++; if ({frame_l, frame_r} !== 48'h0) begin errors++; $display("FAIL mid_reset_frame got %h exp 0", {frame_l, frame_r}); end
    reset = 1'b0; tick();
    r_data = 24'h000803; r_data_en = 1'b1; tick();
    checks++; if (sync_err !== 1'b1 || fifo_level !== 3'd0) begin errors++; $display("FAIL mid_r_first sync %b level %0d exp 1 0", sync_err, fifo_level); end
    r_data_en = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b1;
    l_data_en = 1'b0; r_data_en = 1'b0;
    l_data = '0; r_data = '0;
    frame_ready = 1'b0; clear_overflow = 1'b0;
    test_reset();
    test_basic_frame();
    test_overflow();
    test_full_push_pop();
    test_sync_order();
    test_simultaneous();
    test_set_wins();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
